reg_writeback_unit: RTL and testbench
=====================================

Name: reg_writeback_unit

Overview:
- Writer side of the 32x32 register file: merges ALU results and load responses into a single registered write port (reg_write_en/dest/data).
- Buffers ALU results in a small FIFO while load responses take priority.
- Keeps a scoreboard of outstanding load destinations.
- Reports busy status for the decode stage's rs1/rs2/rd, so decode stalls instead of reading stale data.

Parameters:
- DEPTH, 4, ALU result FIFO entries (power of 2, >=2)
- DATA_W, 32, register data width
- ADDR_W, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  FIFO can accept; transfer when alu_valid&alu_ready
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_issue  in  1  load issued to memory this cycle
- ld_issue_dest  in  ADDR_W  destination of issued load
- ld_valid  in  1  load response (no backpressure; must be taken)
- ld_dest  in  ADDR_W  load response destination
- ld_data  in  DATA_W  load response data
- rs1_addr  in  ADDR_W  decode source 1 query
- rs2_addr  in  ADDR_W  decode source 2 query
- rd_addr  in  ADDR_W  decode destination query
- rs1_busy  out  1  rs1 has a write in flight
- rs2_busy  out  1  rs2 has a write in flight
- rd_busy  out  1  rd has a write in flight
- reg_write_en  out  1  register file write enable
- reg_write_dest  out  ADDR_W  register file write index
- reg_write_data  out  DATA_W  register file write data
- fifo_count  out  $clog2(DEPTH+1)  ALU FIFO occupancy

Behaviour:
- Reset (rst low, async): FIFO emptied, scoreboard cleared. reg_write_en=0, reg_write_dest=0, reg_write_data=0, fifo_count=0. alu_ready=1 once reset is released. Reset mid-operation discards all buffered results and pending loads.
- alu_ready = (fifo_count != DEPTH), combinational from state only. It does not depend on alu_valid.
- Enqueue: an ALU transfer pushes {dest,data} at the clock edge. A transfer with alu_dest==0 completes the handshake but is not enqueued.
- Arbitration each cycle, one write max:
  - If ld_valid: the load wins. If ld_dest!=0, the output register loads {1,ld_dest,ld_data}. The FIFO head is held.
  - Else if the FIFO is non-empty: pop the head; the output register loads {1,head}.
  - Else reg_write_en <= 0.
- Latency: write appears on the reg_write_* outputs exactly 1 cycle after selection. An ALU result entering an empty FIFO with no load competing is written 2 cycles after its handshake. reg_write_en is high for exactly one cycle per result.
- ld_valid with ld_dest==0: no write. The FIFO still does not pop that cycle.
- Simultaneous push and pop: both happen, so count is unchanged. Push when full is impossible because alu_ready=0.
- FIFO is order-preserving; pointers wrap modulo DEPTH.
- Scoreboard pending[31:0]:
  - ld_issue with ld_issue_dest!=0 sets its bit.
  - ld_valid clears pending[ld_dest].
  - Same index set and cleared in one cycle: set wins, because a new load is outstanding.
  - pending[0] is always 0.
- busy(x), combinational, for x in {rs1,rs2,rd}: x!=0 AND (pending[x] OR any valid FIFO entry has dest==x OR (reg_write_en AND reg_write_dest==x) OR (ld_valid AND ld_dest==x)). Address 0 is never busy.
- Ordering contract: decode must not issue an ALU op or a load whose rd_busy=1. Under this contract no WAW reordering between the load path and the ALU path can occur. The block does not check this contract.

Test Plan:
- Reset then single ALU push: alu_dest=5, data=0x12345678 at cycle 0 -> reg_write_en=1, dest=5, data=0x12345678 in cycle 2 only. fifo_count goes 0->1->0.
- Load priority: FIFO holds {3,0xA},{4,0xB} and ld_valid with dest=7, data=0xC arrives -> writes in order 7/0xC, 3/0xA, 4/0xB on consecutive cycles. No entry is lost.
- Full backpressure: DEPTH=4, alu_valid held for 6 cycles while ld_valid is held high every cycle -> alu_ready drops after 4 accepts and fifo_count=4. Releasing ld_valid drains 4 writes in push order, and alu_ready returns to 1 the cycle after the first pop.
- Scoreboard: ld_issue dest=9 -> rs1_busy=1 for rs1_addr=9 the next cycle. ld_valid dest=9 -> busy stays 1 through the write cycle, then 0. ld_issue and ld_valid both to dest 9 in one cycle -> stays busy.
- x0 handling: ALU push dest=0 and load response dest=0 -> handshake completes, no reg_write_en, fifo_count unchanged. rs1_addr=0 is never busy.
- Async reset mid-drain: fifo_count=3, rst pulled low between edges -> reg_write_en=0 and fifo_count=0 immediately, all busy=0. No writes after reset is released.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// Register file writer: merges load responses and buffered ALU results into one
// registered write port, and tracks which registers still have a write in flight.
module reg_writeback_unit #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_W-1:0]            alu_dest,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         ld_issue,
    input  logic [ADDR_W-1:0]            ld_issue_dest,
    input  logic                         ld_valid,
    input  logic [ADDR_W-1:0]            ld_dest,
    input  logic [DATA_W-1:0]            ld_data,
    input  logic [ADDR_W-1:0]            rs1_addr,
    input  logic [ADDR_W-1:0]            rs2_addr,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         rs1_busy,
    output logic                         rs2_busy,
    output logic                         rd_busy,
    output logic                         reg_write_en,
    output logic [ADDR_W-1:0]            reg_write_dest,
    output logic [DATA_W-1:0]            reg_write_data,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ZERO_CNT  = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    // A register is busy if any path still holds a write for it; x0 never is.
    function automatic logic busy_f(
        input logic [ADDR_W-1:0]             a,
        input logic [NREG-1:0]               pend,
        input logic [DEPTH-1:0][ADDR_W-1:0]  dests,
        input logic [DEPTH-1:0]              vld,
        input logic                          wen,
        input logic [ADDR_W-1:0]             wdest,
        input logic                          lv,
        input logic [ADDR_W-1:0]             ldst
    );
        logic hit;
        hit = pend[a] | (wen & (wdest == a)) | (lv & (ldst == a));
        for (int i = 0; i < DEPTH; i++) begin
            hit = hit | (vld[i] & (dests[i] == a));
        end
        return (a != ZERO_ADDR) & hit;
    endfunction

    logic [DEPTH-1:0][ADDR_W-1:0] fifo_dest_r;
    logic [DEPTH-1:0]             fifo_vld_r;
    logic [DATA_W-1:0]            fifo_data_r [DEPTH];
    logic [PTR_W-1:0]             wr_ptr_r;
    logic [PTR_W-1:0]             rd_ptr_r;
    logic [CNT_W-1:0]             count_r;
    logic [NREG-1:0]              pending_r;

    logic                         reg_write_en_r;
    logic [ADDR_W-1:0]            reg_write_dest_r;
    logic [DATA_W-1:0]            reg_write_data_r;

    logic                         alu_ready_s;
    logic                         push_s;
    logic                         pop_s;
    logic                         wr_en_nxt_s;
    logic [ADDR_W-1:0]            wr_dest_nxt_s;
    logic [DATA_W-1:0]            wr_data_nxt_s;

    // Handshake: ready depends on occupancy only; x0 results are accepted and dropped.
    always_comb begin
        alu_ready_s = (count_r != FULL_CNT);
        if (alu_valid && alu_ready_s && (alu_dest != ZERO_ADDR)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Arbitration: a load response always wins and freezes the FIFO head.
    always_comb begin
        wr_en_nxt_s   = 1'b0;
        wr_dest_nxt_s = reg_write_dest_r;
        wr_data_nxt_s = reg_write_data_r;
        pop_s         = 1'b0;
        if (ld_valid) begin
            if (ld_dest != ZERO_ADDR) begin
                wr_en_nxt_s   = 1'b1;
                wr_dest_nxt_s = ld_dest;
                wr_data_nxt_s = ld_data;
            end else begin
                wr_en_nxt_s   = 1'b0;
            end
        end else if (count_r != ZERO_CNT) begin
            pop_s         = 1'b1;
            wr_en_nxt_s   = 1'b1;
            wr_dest_nxt_s = fifo_dest_r[rd_ptr_r];
            wr_data_nxt_s = fifo_data_r[rd_ptr_r];
        end else begin
            wr_en_nxt_s   = 1'b0;
        end
    end

    // FIFO control: pointers, occupancy and per-entry valid/dest used by the busy check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= ZERO_CNT;
            fifo_vld_r  <= {DEPTH{1'b0}};
            fifo_dest_r <= {(DEPTH*ADDR_W){1'b0}};
        end else begin
            if (pop_s) begin
                fifo_vld_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r             <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s) begin
                fifo_vld_r[wr_ptr_r]  <= 1'b1;
                fifo_dest_r[wr_ptr_r] <= alu_dest;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO data storage needs no reset: entries are only read while marked valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= alu_data;
        end
    end

    // Outstanding-load scoreboard; a new issue beats a same-cycle response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= {NREG{1'b0}};
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (ld_issue && (ld_issue_dest == ADDR_W'(i))) begin
                    pending_r[i] <= 1'b1;
                end else if (ld_valid && (ld_dest == ADDR_W'(i))) begin
                    pending_r[i] <= 1'b0;
                end
            end
            pending_r[0] <= 1'b0;
        end
    end

    // Registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_en_r   <= 1'b0;
            reg_write_dest_r <= ZERO_ADDR;
            reg_write_data_r <= {DATA_W{1'b0}};
        end else begin
            reg_write_en_r   <= wr_en_nxt_s;
            reg_write_dest_r <= wr_dest_nxt_s;
            reg_write_data_r <= wr_data_nxt_s;
        end
    end

    // Decode-side busy queries.
    always_comb begin
        rs1_busy = busy_f(rs1_addr, pending_r, fifo_dest_r, fifo_vld_r,
                          reg_write_en_r, reg_write_dest_r, ld_valid, ld_dest);
        rs2_busy = busy_f(rs2_addr, pending_r, fifo_dest_r, fifo_vld_r,
                          reg_write_en_r, reg_write_dest_r, ld_valid, ld_dest);
        rd_busy  = busy_f(rd_addr, pending_r, fifo_dest_r, fifo_vld_r,
                          reg_write_en_r, reg_write_dest_r, ld_valid, ld_dest);
    end

    assign alu_ready      = alu_ready_s;
    assign reg_write_en   = reg_write_en_r;
    assign reg_write_dest = reg_write_dest_r;
    assign reg_write_data = reg_write_data_r;
    assign fifo_count     = count_r;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed self-checking bench for reg_writeback_unit with hand-computed expectations.
module tb_reg_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_dest;
    logic        ld_valid;
    logic [4:0]  ld_dest;
    logic [31:0] ld_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        reg_write_en;
    logic [4:0]  reg_write_dest;
    logic [31:0] reg_write_data;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_writeback_unit #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_dest(ld_issue_dest),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [4:0] d, input logic [31:0] v);
        check_val({tag, "_en"}, 64'(reg_write_en), 64'(en));
        if (en) begin
            check_val({tag, "_dest"}, 64'(reg_write_dest), 64'(d));
            check_val({tag, "_data"}, 64'(reg_write_data), 64'(v));
        end
    endtask

    initial begin
        int acc;
        rst = 1'b0; alu_valid = 1'b0; alu_dest = 5'd0; alu_data = 32'd0;
        ld_issue = 1'b0; ld_issue_dest = 5'd0; ld_valid = 1'b0; ld_dest = 5'd0; ld_data = 32'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;

        // Reset state
        #12;
        check_val("rst_en", 64'(reg_write_en), 64'd0);
        check_val("rst_dest", 64'(reg_write_dest), 64'd0);
        check_val("rst_data", 64'(reg_write_data), 64'd0);
        check_val("rst_count", 64'(fifo_count), 64'd0);
        step();
        rst = 1'b1;
        #1;
        check_val("rst_ready", 64'(alu_ready), 64'd1);

        // Single ALU push: written two cycles after the handshake
        alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'h12345678;
        step();
        alu_valid = 1'b0;
        check_val("single_cnt1", 64'(fifo_count), 64'd1);
        check_wr("single_c1", 1'b0, 5'd0, 32'd0);
        step();
        check_wr("single_c2", 1'b1, 5'd5, 32'h12345678);
        check_val("single_cnt0", 64'(fifo_count), 64'd0);
        step();
        check_wr("single_c3", 1'b0, 5'd0, 32'd0);

        // Load priority; the first cycle also has a load response to x0
        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'hA;
        ld_valid = 1'b1; ld_dest = 5'd0; ld_data = 32'hDEAD;
        rs1_addr = 5'd0;
        #1;
        check_val("x0_rs1_busy", 64'(rs1_busy), 64'd0);
        step();
        check_val("prio_cnt1", 64'(fifo_count), 64'd1);
        check_wr("x0_ld_nowrite", 1'b0, 5'd0, 32'd0);
        alu_dest = 5'd4; alu_data = 32'hB;
        ld_dest = 5'd7; ld_data = 32'hC;
        step();
        alu_valid = 1'b0; ld_valid = 1'b0;
        check_val("prio_cnt2", 64'(fifo_count), 64'd2);
        check_wr("prio_w0", 1'b1, 5'd7, 32'hC);
        step();
        check_wr("prio_w1", 1'b1, 5'd3, 32'hA);
        step();
        check_wr("prio_w2", 1'b1, 5'd4, 32'hB);
        check_val("prio_cnt0", 64'(fifo_count), 64'd0);
        step();
        check_wr("prio_idle", 1'b0, 5'd0, 32'd0);

        // Full backpressure while loads hold the write port
        acc = 0;
        ld_valid = 1'b1; ld_dest = 5'd20; ld_data = 32'h55;
        alu_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            alu_dest = 5'(10 + acc); alu_data = 32'h100 + 32'(acc);
            #1;
            check_val("bp_ready", 64'(alu_ready), 64'(acc < 4));
            step();
            if (acc < 4) acc++;
            check_wr("bp_ldwr", 1'b1, 5'd20, 32'h55);
        end
        check_val("bp_full_cnt", 64'(fifo_count), 64'd4);
        check_val("bp_full_ready", 64'(alu_ready), 64'd0);
        alu_valid = 1'b0; ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_wr("bp_drain", 1'b1, 5'(10 + k), 32'h100 + 32'(k));
            check_val("bp_drain_cnt", 64'(fifo_count), 64'(3 - k));
            check_val("bp_drain_ready", 64'(alu_ready), 64'd1);
        end
        step();
        check_wr("bp_idle", 1'b0, 5'd0, 32'd0);

        // Scoreboard
        rs1_addr = 5'd9;
        ld_issue = 1'b1; ld_issue_dest = 5'd9;
        #1;
        check_val("sb_before", 64'(rs1_busy), 64'd0);
        step();
        ld_issue = 1'b0;
        #1;
        check_val("sb_pending", 64'(rs1_busy), 64'd1);
        ld_valid = 1'b1; ld_dest = 5'd9; ld_data = 32'h99;
        #1;
        check_val("sb_resp", 64'(rs1_busy), 64'd1);
        step();
        ld_valid = 1'b0;
        #1;
        check_val("sb_wcycle", 64'(rs1_busy), 64'd1);
        check_wr("sb_wr", 1'b1, 5'd9, 32'h99);
        step();
        check_val("sb_clear", 64'(rs1_busy), 64'd0);
        ld_issue = 1'b1; ld_issue_dest = 5'd9;
        step();
        ld_valid = 1'b1; ld_dest = 5'd9; ld_data = 32'h98;
        step();
        ld_issue = 1'b0; ld_valid = 1'b0;
        step();
        step();
        check_val("sb_set_wins", 64'(rs1_busy), 64'd1);
        ld_valid = 1'b1; ld_dest = 5'd9;
        step();
        ld_valid = 1'b0;
        step();
        check_val("sb_final_clear", 64'(rs1_busy), 64'd0);

        // ALU push to x0 is accepted but dropped
        alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'hFFFF;
        #1;
        check_val("x0_alu_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 1'b0;
        check_val("x0_alu_cnt", 64'(fifo_count), 64'd0);
        step();
        check_wr("x0_alu_nowrite", 1'b0, 5'd0, 32'd0);

        // Async reset with three buffered results
        ld_valid = 1'b1; ld_dest = 5'd0;
        alu_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            alu_dest = 5'(6 + k); alu_data = 32'h600 + 32'(k);
            if (k == 2) ld_dest = 5'd21;
            step();
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        rs1_addr = 5'd7; rs2_addr = 5'd21; rd_addr = 5'd6;
        #1;
        check_val("ar_cnt3", 64'(fifo_count), 64'd3);
        check_val("ar_rd_busy_fifo", 64'(rd_busy), 64'd1);
        check_val("ar_rs2_busy_wr", 64'(rs2_busy), 64'd1);
        check_wr("ar_pre_wr", 1'b1, 5'd21, 32'h98);
        rst = 1'b0;
        #1;
        check_val("ar_en0", 64'(reg_write_en), 64'd0);
        check_val("ar_cnt0", 64'(fifo_count), 64'd0);
        check_val("ar_busy", 64'({rs1_busy, rs2_busy, rd_busy}), 64'd0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("ar_no_write", 64'(reg_write_en), 64'd0);
        end
        check_val("ar_cnt_after", 64'(fifo_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
